// File: rtl/arm_multicycle_ctrl.sv
// ============================================================================
// arm_multicycle_ctrl : Moore-FSM control unit and NZCV flag register for a
//                       multicycle ARM datapath (DP, LDR/STR, B).
// Revision: 1.0
// ============================================================================
`default_nettype none

module arm_multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        rd_is_pc;
    logic        unused_instr_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign s_bit    = funct[0];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    // Data-processing command decode
    logic        cmd_valid;
    logic        cmd_writes;
    logic        cmd_is_cmp;
    logic [1:0]  cmd_alu;

    always_comb begin
        cmd_valid  = 1'b1;
        cmd_writes = 1'b0;
        cmd_is_cmp = 1'b0;
        cmd_alu    = 2'b00;
        case (cmd)
            CMD_ADD: begin cmd_writes = 1'b1; cmd_alu = 2'b00; end
            CMD_SUB: begin cmd_writes = 1'b1; cmd_alu = 2'b01; end
            CMD_AND: begin cmd_writes = 1'b1; cmd_alu = 2'b10; end
            CMD_ORR: begin cmd_writes = 1'b1; cmd_alu = 2'b11; end
            CMD_CMP: begin cmd_is_cmp = 1'b1; cmd_alu = 2'b01; end
            default: cmd_valid = 1'b0;
        endcase
    end

    // Condition check against the registered flags
    logic        cond_ex;
    logic        fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = fz;
            4'h1: cond_ex = ~fz;
            4'h2: cond_ex = fc;
            4'h3: cond_ex = ~fc;
            4'h4: cond_ex = fn;
            4'h5: cond_ex = ~fn;
            4'h6: cond_ex = fv;
            4'h7: cond_ex = ~fv;
            4'h8: cond_ex = fc & ~fz;
            4'h9: cond_ex = ~fc | fz;
            4'hA: cond_ex = (fn == fv);
            4'hB: cond_ex = (fn != fv);
            4'hC: cond_ex = ~fz & (fn == fv);
            4'hD: cond_ex = fz | (fn != fv);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) &&
            cmd_valid && (s_bit || cmd_is_cmp) && cond_ex)
            flags_d = ALUFlags;
    end

    logic        pc_write;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;

    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        RegSrc     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = 2'b01;
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                RegSrc  = 2'b10;
                state_d = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            // A result destined for R15 is steered into the PC instead
            S_MEMWB: begin
                ResultSrc = 2'b01;
                pc_write  = cond_ex & rd_is_pc;
                reg_write = cond_ex & ~rd_is_pc;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                mem_write = cond_ex;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = cmd_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                pc_write  = cond_ex & rd_is_pc;
                reg_write = cond_ex & cmd_writes & ~rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                RegSrc    = 2'b01;
                pc_write  = cond_ex;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWrite  = pc_write  & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign IRWrite  = ir_write  & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign ImmSrc   = op;
    assign Flags    = flags_q;
    assign State    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_arm_multicycle_ctrl.sv
// ============================================================================
// tb_arm_multicycle_ctrl : directed and randomized bench with an
//                          instruction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  Flags, State;

    arm_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;

    // Reference model: state number, flag register, remaining instruction path
    int          m_state = 0;
    logic [3:0]  m_flags = 4'h0;
    bit          m_valid = 1'b0;
    int          m_path[$];

    // Snapshot of the DUT taken mid-cycle by cyc()
    int          s_state, s_flags, s_pcw, s_rw, s_mw, s_adr, s_rs, s_sb, s_regsrc;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic condex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic bit is_cmd(input logic [3:0] c);
        return c == 4'h4 || c == 4'h2 || c == 4'h0 || c == 4'hC || c == 4'hA;
    endfunction

    function automatic bit writes_cmd(input logic [3:0] c);
        return c == 4'h4 || c == 4'h2 || c == 4'h0 || c == 4'hC;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] c);
        if (c == 4'h2 || c == 4'hA) return 2'b01;
        if (c == 4'h0) return 2'b10;
        if (c == 4'hC) return 2'b11;
        return 2'b00;
    endfunction

    // Expected {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,
    //           ALUControl,ImmSrc,RegSrc,RegWrite,Flags,State}
    function automatic logic [23:0] exp_out(input int st, input logic [31:0] ins,
                                            input logic [3:0] fl, input logic r);
        logic       pcw, adr, mw, irw, sa, rw, ce, rd15;
        logic [1:0] rs, sb, ac, rsrc;
        logic [3:0] st4;
        pcw = 0; adr = 0; mw = 0; irw = 0; sa = 0; rw = 0;
        rs = 0; sb = 0; ac = 0; rsrc = 0;
        ce   = condex(ins[31:28], fl);
        rd15 = (ins[15:12] == 4'hF);
        st4  = st[3:0];
        case (st)
            0: begin irw = 1; sa = 1; sb = 2; rs = 2; pcw = 1; end
            1: begin sa = 1; sb = 2; rs = 2; rsrc = 2'b01; end
            2: begin sb = 1; rsrc = 2'b10; end
            3: adr = 1;
            4: begin rs = 1; if (rd15) pcw = ce; else rw = ce; end
            5: begin adr = 1; mw = ce; end
            6, 7: begin sb = (st == 7) ? 2'b01 : 2'b00; ac = alu_of(ins[24:21]); end
            8: begin if (rd15) pcw = ce; else rw = ce && writes_cmd(ins[24:21]); end
            9: begin sb = 1; rs = 2; rsrc = 2'b01; pcw = ce; end
            default: ;
        endcase
        if (r) begin pcw = 0; mw = 0; irw = 0; rw = 0; end
        return {pcw, adr, mw, irw, rs, sa, sb, ac, ins[27:26], rsrc, rw, fl, st4};
    endfunction

    // One clock cycle: apply inputs, compare mid-cycle, advance the model.
    task automatic cyc(input logic r, input logic [31:0] ins, input logic [3:0] af);
        logic [23:0] act;
        reset = r; Instr = ins; ALUFlags = af;
        #1;
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, Flags, State};
        s_state = int'(State); s_flags = int'(Flags); s_pcw = int'(PCWrite);
        s_rw = int'(RegWrite); s_mw = int'(MemWrite); s_adr = int'(AdrSrc);
        s_rs = int'(ResultSrc); s_sb = int'(ALUSrcB); s_regsrc = int'(RegSrc);
        if (m_valid)
            chk("outputs", int'(act), int'(exp_out(m_state, ins, m_flags, r)));
        else
            chk("reset_strobes", int'({PCWrite, IRWrite, MemWrite, RegWrite}), 0);
        if (r) begin
            m_state = 0; m_flags = 4'h0; m_path.delete(); m_valid = 1'b1;
        end else begin
            if ((m_state == 6 || m_state == 7) && is_cmd(ins[24:21]) &&
                (ins[20] || ins[24:21] == 4'hA) && condex(ins[31:28], m_flags))
                m_flags = af;
            if (m_state == 0) begin
                case (ins[27:26])
                    2'b01:   m_path = ins[20] ? '{1, 2, 3, 4, 0} : '{1, 2, 5, 0};
                    2'b00:   m_path = '{1, ins[25] ? 7 : 6, 8, 0};
                    2'b10:   m_path = '{1, 9, 0};
                    default: m_path = '{1, 0};
                endcase
            end
            m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'he2802005;
    localparam logic [31:0] I_SUBS = 32'he2523005;
    localparam logic [31:0] I_BEQ  = 32'h0a000001;
    localparam logic [31:0] I_BNE  = 32'h1a000001;
    localparam logic [31:0] I_LDR  = 32'he5904008;
    localparam logic [31:0] I_STR  = 32'he5804008;
    localparam logic [31:0] I_ADDS = 32'he2902005;

    initial begin
        int          seq_add[4] = '{0, 1, 7, 8};
        int          seq_ldr[5] = '{0, 1, 2, 3, 4};
        int          seq_str[4] = '{0, 1, 2, 5};
        int          seq_b[3]   = '{0, 1, 9};
        logic [31:0] cur;
        logic        r;

        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, I_ADD, 4'h0);
            chk("reset_writes", s_pcw + s_rw + s_mw, 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, I_ADD, 4'hF);
            chk("add_state", s_state, seq_add[i]);
            chk("add_regwrite", s_rw, (i == 3) ? 1 : 0);
            if (i == 2) chk("add_alusrcb", s_sb, 1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, I_SUBS, (i == 2) ? 4'b0100 : 4'b1011);
            if (i == 0) chk("add_back_to_fetch", s_state, 0);
            if (i == 3) begin
                chk("subs_flags", s_flags, 4'b0100);
                chk("subs_regwrite", s_rw, 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, I_BEQ, 4'h0);
            chk("beq_state", s_state, seq_b[i]);
        end
        chk("beq_pcwrite", s_pcw, 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, I_BNE, 4'h0);
        chk("bne_state", s_state, 9);
        chk("bne_pcwrite", s_pcw, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, I_LDR, 4'h0);
            chk("ldr_state", s_state, seq_ldr[i]);
            if (i == 3) chk("ldr_adrsrc", s_adr, 1);
            if (i == 4) begin
                chk("ldr_resultsrc", s_rs, 1);
                chk("ldr_regwrite", s_rw, 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, I_STR, 4'h0);
            chk("str_state", s_state, seq_str[i]);
            if (i == 2) chk("str_regsrc1", s_regsrc >> 1, 1);
            if (i == 3) chk("str_memwrite", s_mw, 1);
        end
        cyc(1'b0, I_ADDS, 4'h0);
        cyc(1'b0, I_ADDS, 4'h0);
        cyc(1'b1, I_ADDS, 4'hF);
        chk("abort_state", s_state, 7);
        chk("abort_regwrite", s_rw, 0);
        cyc(1'b0, I_ADDS, 4'h0);
        chk("abort_next_state", s_state, 0);
        chk("abort_flags", s_flags, 0);
        chk("abort_regwrite_after", s_rw, 0);

        cur = I_ADD;
        for (int n = 0; n < 3000; n++) begin
            if (m_state == 0) begin
                cur = $urandom;
                if ($urandom_range(0, 3) == 0) cur[31:28] = 4'hE;
                if ($urandom_range(0, 1) == 0) begin
                    case ($urandom_range(0, 4))
                        0: cur[24:21] = 4'h4;
                        1: cur[24:21] = 4'h2;
                        2: cur[24:21] = 4'h0;
                        3: cur[24:21] = 4'hC;
                        default: cur[24:21] = 4'hA;
                    endcase
                end
                if ($urandom_range(0, 5) == 0) cur[15:12] = 4'hF;
            end
            r = ($urandom_range(0, 49) == 0);
            cyc(r, cur, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
